logic_analyzer_seq: RTL and testbench



---
 rtl/logic_analyzer_seq_if.sv | 41 ++++
 rtl/logic_analyzer_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_logic_analyzer_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_analyzer_seq_if.sv
// Capture-core bus: probe data, trigger/capture configuration, readout and status.
interface logic_analyzer_seq_if #(
  parameter int unsigned CAPTURE_WIDTH = 32,
  parameter int unsigned CAPTURE_DEPTH = 10,
  parameter int unsigned NUM_STAGES    = 2
);
  logic [CAPTURE_WIDTH-1:0]            i_cap_data;
  logic                                i_ext_trig;
  logic                                i_enable;
  logic                                i_force_stb;
  logic [NUM_STAGES*CAPTURE_WIDTH-1:0] i_trig_value;
  logic [NUM_STAGES*CAPTURE_WIDTH-1:0] i_trig_mask;
  logic [NUM_STAGES*CAPTURE_WIDTH-1:0] i_trig_edge;
  logic [NUM_STAGES*CAPTURE_WIDTH-1:0] i_trig_both;
  logic [31:0]                         i_pre_count;
  logic [15:0]                         i_sample_div;
  logic [CAPTURE_DEPTH-1:0]            i_rd_addr;
  logic [CAPTURE_WIDTH-1:0]            o_rd_data;
  logic [CAPTURE_DEPTH-1:0]            o_capture_start;
  logic                                o_triggered;
  logic                                o_finished;
  logic                                o_busy;
  logic [1:0]                          o_stage;
  logic [31:0]                         o_capture_size;

  modport master (
    output i_cap_data, i_ext_trig, i_enable, i_force_stb,
           i_trig_value, i_trig_mask, i_trig_edge, i_trig_both,
           i_pre_count, i_sample_div, i_rd_addr,
    input  o_rd_data, o_capture_start, o_triggered, o_finished,
           o_busy, o_stage, o_capture_size
  );

  modport slave (
    input  i_cap_data, i_ext_trig, i_enable, i_force_stb,
           i_trig_value, i_trig_mask, i_trig_edge, i_trig_both,
           i_pre_count, i_sample_div, i_rd_addr,
    output o_rd_data, o_capture_start, o_triggered, o_finished,
           o_busy, o_stage, o_capture_size
  );
endinterface

// File: rtl/logic_analyzer_seq.sv
// Logic-analyzer capture core: decimated sampling, pre-trigger history,
// multi-stage sequential trigger, abort, and a read-first readout port.
module logic_analyzer_seq #(
  parameter int unsigned CAPTURE_WIDTH = 32,
  parameter int unsigned CAPTURE_DEPTH = 10,
  parameter int unsigned NUM_STAGES    = 2
) (
  input logic                 i_cap_clk,
  input logic                 rst,
  logic_analyzer_seq_if.slave bus
);
  localparam int unsigned W    = CAPTURE_WIDTH;
  localparam int unsigned AW   = CAPTURE_DEPTH;
  localparam int unsigned CW   = NUM_STAGES * CAPTURE_WIDTH;
  localparam int unsigned SIZE = 2 ** CAPTURE_DEPTH;
  localparam logic [AW-1:0] P_MAX = {AW{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_PRE_FILL, S_ARMED, S_POST, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   pre_cfg_q, pre_cfg_d;
  logic [AW-1:0]   cap_start_q, cap_start_d;
  logic [15:0]     div_cnt_q, div_cnt_d;
  logic [15:0]     div_cfg_q, div_cfg_d;
  logic [1:0]      stage_q, stage_d;
  logic [W-1:0]    prev_q, prev_d;
  logic [CW-1:0]   trig_val_q, trig_val_d;
  logic [CW-1:0]   trig_mask_q, trig_mask_d;
  logic [CW-1:0]   trig_edge_q, trig_edge_d;
  logic [CW-1:0]   trig_both_q, trig_both_d;
  logic            force_pend_q, force_pend_d;
  logic            triggered_q, triggered_d;
  logic            finished_q, finished_d;
  logic            busy_q, busy_d;
  logic [W-1:0]    rd_data_q;
  logic [W-1:0]    mem [SIZE];

  logic                  tick_c, we_c, cur_hit_c, last_stage_c, trig_c;
  logic [AW-1:0]         pre_eff_c;
  logic [W-1:0]          rise_c, fall_c;
  logic [NUM_STAGES-1:0] stage_hit_c;

  assign rise_c    = ~prev_q & bus.i_cap_data;
  assign fall_c    = prev_q & ~bus.i_cap_data;
  assign pre_eff_c = (bus.i_pre_count > 32'(P_MAX)) ? P_MAX : bus.i_pre_count[AW-1:0];
  assign tick_c    = (div_cnt_q == 16'd0);

  // Per-stage match: every participating bit must satisfy its level or edge rule.
  always_comb begin
    stage_hit_c = '1;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      for (int unsigned b = 0; b < W; b++) begin
        if (trig_mask_q[k*W+b]) begin
          if (trig_edge_q[k*W+b]) begin
            if (trig_both_q[k*W+b])
              stage_hit_c[k] = stage_hit_c[k] & (rise_c[b] | fall_c[b]);
            else if (trig_val_q[k*W+b])
              stage_hit_c[k] = stage_hit_c[k] & rise_c[b];
            else
              stage_hit_c[k] = stage_hit_c[k] & fall_c[b];
          end else begin
            stage_hit_c[k] = stage_hit_c[k] & (bus.i_cap_data[b] == trig_val_q[k*W+b]);
          end
        end
      end
    end
  end

  always_comb begin
    cur_hit_c = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++)
      if (stage_q == 2'(k)) cur_hit_c = stage_hit_c[k];
    last_stage_c = (stage_q == 2'(NUM_STAGES - 1));
    trig_c = bus.i_ext_trig | force_pend_q | (cur_hit_c & last_stage_c);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    pre_cfg_d    = pre_cfg_q;
    cap_start_d  = cap_start_q;
    div_cfg_d    = div_cfg_q;
    div_cnt_d    = tick_c ? div_cfg_q : div_cnt_q - 16'd1;
    stage_d      = stage_q;
    prev_d       = tick_c ? bus.i_cap_data : prev_q;
    trig_val_d   = trig_val_q;
    trig_mask_d  = trig_mask_q;
    trig_edge_d  = trig_edge_q;
    trig_both_d  = trig_both_q;
    force_pend_d = force_pend_q;
    triggered_d  = triggered_q;
    we_c         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_enable) begin
          trig_val_d   = bus.i_trig_value;
          trig_mask_d  = bus.i_trig_mask;
          trig_edge_d  = bus.i_trig_edge;
          trig_both_d  = bus.i_trig_both;
          pre_cfg_d    = pre_eff_c;
          div_cfg_d    = bus.i_sample_div;
          div_cnt_d    = 16'd0;
          cnt_d        = pre_eff_c;
          wr_ptr_d     = '0;
          stage_d      = 2'd0;
          triggered_d  = 1'b0;
          force_pend_d = 1'b0;
          state_d      = (pre_eff_c != '0) ? S_PRE_FILL : S_ARMED;
        end
      end
      S_PRE_FILL: begin
        if (!bus.i_enable) begin
          state_d      = S_IDLE;
          force_pend_d = 1'b0;
          stage_d      = 2'd0;
        end else begin
          if (bus.i_force_stb) force_pend_d = 1'b1;
          if (tick_c) begin
            we_c  = 1'b1;
            cnt_d = cnt_q - AW'(1);
            if (cnt_q == AW'(1)) state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (!bus.i_enable) begin
          state_d      = S_IDLE;
          force_pend_d = 1'b0;
          stage_d      = 2'd0;
        end else begin
          if (bus.i_force_stb) force_pend_d = 1'b1;
          if (tick_c) begin
            we_c = 1'b1;
            if (trig_c) begin
              cap_start_d = wr_ptr_q - pre_cfg_q;
              triggered_d = 1'b1;
              cnt_d       = P_MAX - pre_cfg_q;
              state_d     = S_POST;
            end else if (cur_hit_c) begin
              stage_d = stage_q + 2'd1;
            end
          end
        end
      end
      S_POST: begin
        if (!bus.i_enable) begin
          state_d      = S_IDLE;
          force_pend_d = 1'b0;
          stage_d      = 2'd0;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else if (tick_c) begin
          we_c  = 1'b1;
          cnt_d = cnt_q - AW'(1);
        end
      end
      S_DONE: begin
        if (!bus.i_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (we_c) wr_ptr_d = wr_ptr_q + AW'(1);
    busy_d     = (state_d == S_PRE_FILL) || (state_d == S_ARMED) || (state_d == S_POST);
    finished_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_cap_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      pre_cfg_q    <= '0;
      cap_start_q  <= '0;
      div_cnt_q    <= '0;
      div_cfg_q    <= '0;
      stage_q      <= '0;
      prev_q       <= '0;
      trig_val_q   <= '0;
      trig_mask_q  <= '0;
      trig_edge_q  <= '0;
      trig_both_q  <= '0;
      force_pend_q <= 1'b0;
      triggered_q  <= 1'b0;
      finished_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      pre_cfg_q    <= pre_cfg_d;
      cap_start_q  <= cap_start_d;
      div_cnt_q    <= div_cnt_d;
      div_cfg_q    <= div_cfg_d;
      stage_q      <= stage_d;
      prev_q       <= prev_d;
      trig_val_q   <= trig_val_d;
      trig_mask_q  <= trig_mask_d;
      trig_edge_q  <= trig_edge_d;
      trig_both_q  <= trig_both_d;
      force_pend_q <= force_pend_d;
      triggered_q  <= triggered_d;
      finished_q   <= finished_d;
      busy_q       <= busy_d;
    end
  end

  // Sample buffer: not cleared by reset, read-first on address collision.
  always_ff @(posedge i_cap_clk) begin
    if (we_c && !rst) mem[wr_ptr_q] <= bus.i_cap_data;
    rd_data_q <= mem[bus.i_rd_addr];
  end

  assign bus.o_rd_data       = rd_data_q;
  assign bus.o_capture_start = cap_start_q;
  assign bus.o_triggered     = triggered_q;
  assign bus.o_finished      = finished_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_stage         = stage_q;
  assign bus.o_capture_size  = 32'(SIZE);
endmodule

// File: tb/tb_logic_analyzer_seq.sv
// Bench for logic_analyzer_seq: spec-level model compared every cycle plus directed literals.
module tb_logic_analyzer_seq;
  localparam int unsigned W = 8, D = 4, NS = 2, SZ = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_analyzer_seq_if #(.CAPTURE_WIDTH(W), .CAPTURE_DEPTH(D), .NUM_STAGES(NS)) la ();
  logic_analyzer_seq #(.CAPTURE_WIDTH(W), .CAPTURE_DEPTH(D), .NUM_STAGES(NS)) dut (
    .i_cap_clk(clk), .rst(rst), .bus(la)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: phase 0=idle 1=pre-fill 2=armed 3=post 4=done
  int         m_phase = 0, m_since = 0, m_div = 0, m_pre = 0, m_written = 0, m_wr = 0;
  int         m_cap = 0, m_stage = 0;
  bit         m_trig = 0, m_force = 0, m_rd_known = 0;
  logic [7:0] m_prev = 0, m_rd = 0;
  logic [7:0] m_val [NS], m_mask [NS], m_edge [NS], m_both [NS];
  logic [7:0] m_mem [SZ];
  bit         m_known [SZ];

  function automatic bit mmatch(input int k, input logic [7:0] d, input logic [7:0] p);
    logic [7:0] rise, fall, eok, bad;
    rise = ~p & d;
    fall = p & ~d;
    eok  = (m_both[k] & (rise | fall)) | (~m_both[k] & m_val[k] & rise) |
           (~m_both[k] & ~m_val[k] & fall);
    bad  = ((d ^ m_val[k]) & m_mask[k] & ~m_edge[k]) | (m_mask[k] & m_edge[k] & ~eok);
    return bad == 8'h00;
  endfunction

  always @(posedge clk) begin : model
    bit tick, wr, trg;
    logic [7:0] d;
    d = la.i_cap_data;
    m_rd = m_mem[la.i_rd_addr];
    m_rd_known = m_known[la.i_rd_addr];
    if (rst) begin
      m_phase = 0; m_since = 0; m_div = 0; m_pre = 0; m_written = 0; m_wr = 0;
      m_cap = 0; m_stage = 0; m_trig = 0; m_force = 0; m_prev = 0;
    end else begin
      tick = (m_since % (m_div + 1)) == 0;
      m_since++;
      wr = 0;
      if (m_phase >= 1 && m_phase <= 3 && !la.i_enable) begin
        m_phase = 0; m_force = 0; m_stage = 0;
      end else begin
        case (m_phase)
          0: if (la.i_enable) begin
               for (int k = 0; k < NS; k++) begin
                 m_val[k]  = la.i_trig_value[k*8 +: 8];
                 m_mask[k] = la.i_trig_mask[k*8 +: 8];
                 m_edge[k] = la.i_trig_edge[k*8 +: 8];
                 m_both[k] = la.i_trig_both[k*8 +: 8];
               end
               m_pre = (la.i_pre_count > 32'(SZ - 1)) ? SZ - 1 : int'(la.i_pre_count);
               m_div = int'(la.i_sample_div);
               m_since = 0; m_wr = 0; m_stage = 0; m_trig = 0; m_force = 0; m_written = 0;
               m_phase = (m_pre > 0) ? 1 : 2;
             end
          1: begin
               if (la.i_force_stb) m_force = 1;
               if (tick) begin
                 wr = 1; m_written++;
                 if (m_written == m_pre) m_phase = 2;
               end
             end
          2: begin
               if (tick) begin
                 wr = 1;
                 trg = la.i_ext_trig || m_force || (m_stage == NS - 1 && mmatch(m_stage, d, m_prev));
                 if (trg) begin
                   m_cap = (m_wr - m_pre + SZ) % SZ;
                   m_trig = 1; m_written = 0; m_phase = 3;
                 end else if (mmatch(m_stage, d, m_prev)) begin
                   m_stage++;
                 end
               end
               if (la.i_force_stb) m_force = 1;
             end
          3: begin
               if (m_written == SZ - 1 - m_pre) m_phase = 4;
               else if (tick) begin wr = 1; m_written++; end
             end
          default: if (!la.i_enable) m_phase = 0;
        endcase
      end
      if (wr) begin
        m_mem[m_wr] = d; m_known[m_wr] = 1; m_wr = (m_wr + 1) % SZ;
      end
      if (tick) m_prev = d;
    end
  end

  always @(negedge clk) begin : compare
    chk("triggered", 32'(la.o_triggered), 32'(m_trig));
    chk("finished", 32'(la.o_finished), 32'(m_phase == 4));
    chk("busy", 32'(la.o_busy), 32'(m_phase >= 1 && m_phase <= 3));
    chk("stage", 32'(la.o_stage), 32'(m_stage));
    chk("capture_start", 32'(la.o_capture_start), 32'(m_cap));
    chk("capture_size", la.o_capture_size, 32'(SZ));
    if (m_rd_known) chk("rd_data", 32'(la.o_rd_data), 32'(m_rd));
  end

  task automatic cfg(input int k, input logic [7:0] v, input logic [7:0] m,
                     input logic [7:0] e, input logic [7:0] b);
    la.i_trig_value[k*8 +: 8] = v;
    la.i_trig_mask[k*8 +: 8]  = m;
    la.i_trig_edge[k*8 +: 8]  = e;
    la.i_trig_both[k*8 +: 8]  = b;
  endtask

  task automatic drv(input logic [7:0] d);
    la.i_cap_data = d;
    @(negedge clk);
  endtask

  task automatic rd(input int a, input logic [7:0] exp, input string nm);
    la.i_rd_addr = 4'(a);
    @(negedge clk);
    chk(nm, 32'(la.o_rd_data), 32'(exp));
  endtask

  // Ramp data = cycle index from the arm cycle until o_finished; returns that index.
  task automatic run(input int budget, input int force_at, output int n);
    n = -1;
    for (int i = 0; i < budget; i++) begin
      la.i_cap_data  = 8'(i);
      la.i_force_stb = (i == force_at);
      @(negedge clk);
      if (la.o_finished) begin n = i; break; end
    end
    la.i_force_stb = 1'b0;
    if (n < 0) begin
      n_chk++; n_err++;
      $display("FAIL run_timeout: o_finished not seen within %0d cycles", budget);
    end
  endtask

  task automatic disarm();
    la.i_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    la.i_cap_data = '0; la.i_ext_trig = 1'b0; la.i_enable = 1'b0; la.i_force_stb = 1'b0;
    la.i_trig_value = '0; la.i_trig_mask = '0; la.i_trig_edge = '0; la.i_trig_both = '0;
    la.i_pre_count = '0; la.i_sample_div = '0; la.i_rd_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_size", la.o_capture_size, 32'd16);
    chk("rst_busy", 32'(la.o_busy), 32'd0);
    chk("rst_triggered", 32'(la.o_triggered), 32'd0);
    chk("rst_stage", 32'(la.o_stage), 32'd0);

    // 1: stage0 level bit0, stage1 always -> trigger sample 0x02 at addr 1
    cfg(0, 8'h01, 8'h01, 8'h00, 8'h00); cfg(1, 8'h00, 8'h00, 8'h00, 8'h00);
    la.i_pre_count = 0; la.i_sample_div = 0; la.i_enable = 1'b1;
    run(60, -1, n);
    chk("t1_done_cycle", 32'(n), 32'd18);
    chk("t1_start", 32'(la.o_capture_start), 32'd1);
    rd(1, 8'h02, "t1_trig_sample");
    rd(0, 8'h11, "t1_last_sample");
    rd(15, 8'h10, "t1_addr15");
    la.i_enable = 1'b0;
    @(negedge clk);
    chk("t1_fin_clear", 32'(la.o_finished), 32'd0);
    chk("t1_trig_hold", 32'(la.o_triggered), 32'd1);
    chk("t1_start_hold", 32'(la.o_capture_start), 32'd1);
    @(negedge clk);

    // 2: P=5, trigger on 0x20 after ARMED wraps the buffer
    cfg(0, 8'h00, 8'h00, 8'h00, 8'h00); cfg(1, 8'h20, 8'hFF, 8'h00, 8'h00);
    la.i_pre_count = 5; la.i_enable = 1'b1;
    run(80, -1, n);
    chk("t2_done_cycle", 32'(n), 32'd43);
    chk("t2_start", 32'(la.o_capture_start), 32'd10);
    rd(15, 8'h20, "t2_trig_sample");
    rd(14, 8'h1F, "t2_pre_last");
    rd(10, 8'h1B, "t2_oldest");
    rd(9, 8'h2A, "t2_newest");
    disarm();

    // 3: stage0 rising edge bit0, stage1 level 0xAA
    cfg(0, 8'h01, 8'h01, 8'h01, 8'h00); cfg(1, 8'hAA, 8'hFF, 8'h00, 8'h00);
    la.i_pre_count = 0; la.i_enable = 1'b1;
    drv(8'h00);
    drv(8'hAA);
    chk("t3_no_adv_stage", 32'(la.o_stage), 32'd0);
    drv(8'hAA);
    chk("t3_no_trig", 32'(la.o_triggered), 32'd0);
    drv(8'h00);
    drv(8'h01);
    chk("t3_stage1", 32'(la.o_stage), 32'd1);
    chk("t3_not_yet", 32'(la.o_triggered), 32'd0);
    drv(8'hAA);
    chk("t3_trig", 32'(la.o_triggered), 32'd1);
    chk("t3_start", 32'(la.o_capture_start), 32'd4);
    disarm();
    chk("t3_abort_busy", 32'(la.o_busy), 32'd0);
    chk("t3_abort_fin", 32'(la.o_finished), 32'd0);

    // 4 + 6a: div=3 decimation, value between ticks missed, then abort in ARMED
    cfg(0, 8'h00, 8'h00, 8'h00, 8'h00); cfg(1, 8'h07, 8'hFF, 8'h00, 8'h00);
    la.i_sample_div = 3; la.i_enable = 1'b1;
    for (int i = 0; i < 40; i++) drv(8'(i));
    chk("t4_missed", 32'(la.o_triggered), 32'd0);
    chk("t4_stage", 32'(la.o_stage), 32'd1);
    rd(0, 8'h01, "t4_s0");
    rd(1, 8'h05, "t4_s1");
    rd(2, 8'h09, "t4_s2");
    la.i_enable = 1'b0;
    @(negedge clk);
    chk("t6_abort_stage", 32'(la.o_stage), 32'd0);
    chk("t6_abort_busy", 32'(la.o_busy), 32'd0);
    chk("t6_abort_fin", 32'(la.o_finished), 32'd0);
    @(negedge clk);

    // 5: P=20 clamps to 15, force in PRE_FILL
    cfg(1, 8'hFF, 8'hFF, 8'h00, 8'h00);
    la.i_sample_div = 0; la.i_pre_count = 20; la.i_enable = 1'b1;
    run(60, 3, n);
    chk("t5_done_cycle", 32'(n), 32'd17);
    chk("t5_start", 32'(la.o_capture_start), 32'd0);
    rd(15, 8'h10, "t5_trig_sample");
    rd(0, 8'h01, "t5_oldest");
    disarm();

    // 6b: rst during POST
    cfg(1, 8'h00, 8'h00, 8'h00, 8'h00);
    la.i_pre_count = 0; la.i_enable = 1'b1;
    drv(8'h00); drv(8'h01); drv(8'h02); drv(8'h03);
    chk("t6_in_post", 32'(la.o_busy), 32'd1);
    rst = 1'b1;
    drv(8'h04);
    rst = 1'b0; la.i_enable = 1'b0;
    chk("t6_rst_trig", 32'(la.o_triggered), 32'd0);
    chk("t6_rst_busy", 32'(la.o_busy), 32'd0);
    chk("t6_rst_stage", 32'(la.o_stage), 32'd0);
    chk("t6_rst_start", 32'(la.o_capture_start), 32'd0);
    chk("t6_rst_size", la.o_capture_size, 32'd16);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
